// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stall, multicycle mul/div stall,
// taken-branch flush, and a saturating count of stalled cycles.
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | normal issue; load-use and mul/div start are detected here
// MD_WAIT | mul/div occupying EX; cnt counts remaining stall cycles
module hazard_control #(
  // Total cycles a mul/div spends in EX; legal range 2..16.
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        ex_md_start,
  input  logic        mem_br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ex_hold,
  output logic        exmem_bubble,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} stateT;

  // The start cycle itself is the first stall, so MD_WAIT covers the rest.
  localparam logic [3:0] CntLoad = 4'(MD_CYCLES - 2);

  stateT      state, stateNext;
  logic [3:0] cnt, cntNext;
  logic       loadUse;

  // Register 0 is hardwired, so a load to it can never create a hazard.
  assign loadUse = ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State, counter and stall statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= 4'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (!pc_write && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Next-state and control outputs; a taken branch overrides every stall.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    flush_exmem  = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (reset) begin
      stateNext = RUN;
      cntNext   = 4'd0;
    end else begin
      md_busy = (state == MD_WAIT);
      if (mem_br_taken) begin
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        flush_exmem = 1'b1;
        stateNext   = RUN;
        if (state == MD_WAIT) cntNext = 4'd0;
      end else begin
        case (state)
          RUN: begin
            if (ex_md_start) begin
              pc_write     = 1'b0;
              ifid_write   = 1'b0;
              ex_hold      = 1'b1;
              exmem_bubble = 1'b1;
              stateNext    = MD_WAIT;
              cntNext      = CntLoad;
            end else if (loadUse) begin
              pc_write    = 1'b0;
              ifid_write  = 1'b0;
              idex_bubble = 1'b1;
            end
          end
          MD_WAIT: begin
            if (cnt != 4'd0) begin
              pc_write     = 1'b0;
              ifid_write   = 1'b0;
              ex_hold      = 1'b1;
              exmem_bubble = 1'b1;
              cntNext      = cnt - 4'd1;
            end else begin
              md_done   = 1'b1;
              stateNext = RUN;
            end
          end
          default: stateNext = RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

  localparam int MD = 4;

  logic        clk = 1'b0;
  logic        reset, id_uses_rt, ex_mem_read, ex_md_start, mem_br_taken;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        pc_write, ifid_write, idex_bubble, ex_hold, exmem_bubble;
  logic        flush_ifid, flush_idex, flush_exmem, md_busy, md_done;
  logic [15:0] stall_cnt;
  logic [9:0]  outs;

  int          checks = 0;
  int          failures = 0;

  // Reference model: cycles elapsed since the mul/div started (0 = idle).
  int          mPhase = 0;
  logic [15:0] mSc = 16'd0;

  hazard_control #(.MD_CYCLES(MD)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .ex_md_start(ex_md_start), .mem_br_taken(mem_br_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ex_hold(ex_hold), .exmem_bubble(exmem_bubble), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .flush_exmem(flush_exmem), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt)
  );

  assign outs = {pc_write, ifid_write, idex_bubble, ex_hold, exmem_bubble,
                 flush_ifid, flush_idex, flush_exmem, md_busy, md_done};

  always #5 clk = ~clk;

  function automatic logic [9:0] expVec();
    logic pcw, ifw, bub, hold, emb, fl, busy, done, lu;
    pcw = 1'b1; ifw = 1'b1; bub = 1'b0; hold = 1'b0; emb = 1'b0;
    fl = 1'b0; done = 1'b0;
    busy = (mPhase > 0) && !reset;
    lu = ex_mem_read && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (reset) begin
    end else if (mem_br_taken) fl = 1'b1;
    else if (mPhase > 0) begin
      if (mPhase < MD - 1) begin pcw = 0; ifw = 0; hold = 1; emb = 1; end
      else done = 1'b1;
    end else if (ex_md_start) begin pcw = 0; ifw = 0; hold = 1; emb = 1; end
    else if (lu) begin pcw = 0; ifw = 0; bub = 1; end
    return {pcw, ifw, bub, hold, emb, fl, fl, fl, busy, done};
  endfunction

  // Advance the model across the coming clock edge using current inputs.
  task automatic advance();
    logic [9:0] e;
    e = expVec();
    if (reset) begin
      mPhase = 0; mSc = 16'd0;
    end else begin
      if (!e[9] && mSc != 16'hFFFF) mSc = mSc + 16'd1;
      if (mem_br_taken) mPhase = 0;
      else if (mPhase > 0) mPhase = (mPhase == MD - 1) ? 0 : mPhase + 1;
      else if (ex_md_start) mPhase = 1;
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] ert, input logic mr,
                       input logic ms, input logic br);
    @(negedge clk);
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rt = ert;
    ex_mem_read = mr; ex_md_start = ms; mem_br_taken = br;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, i[0]);
      checks++;
      if (outs !== 10'b1100000000) begin
        failures++; $display("FAIL reset_outs got=%b exp=%b", outs, 10'b1100000000);
      end
      advance();
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 16'd0 || md_busy !== 1'b0) begin
      failures++; $display("FAIL reset_state stall_cnt=%0d busy=%b exp 0/0", stall_cnt, md_busy);
    end
    advance();
  endtask

  task automatic test_load_use();
    drive(1'b0, 5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (outs !== 10'b0010000000) begin
      failures++; $display("FAIL load_use got=%b exp=%b", outs, 10'b0010000000);
    end
    advance();
    drive(1'b0, 5'd5, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (outs !== 10'b1100000000 || stall_cnt !== 16'd1) begin
      failures++; $display("FAIL load_use_after got=%b cnt=%0d exp=1100000000 cnt=1", outs, stall_cnt);
    end
    advance();
  endtask

  task automatic test_reg0_rt_unused();
    logic [9:0] want [3];
    want[0] = 10'b1100000000; want[1] = 10'b1100000000; want[2] = 10'b0010000000;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1'b0, 5'd0, 5'd4, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      else        drive(1'b0, 5'd9, 5'd7, i == 2, 5'd7, 1'b1, 1'b0, 1'b0);
      checks++;
      if (outs !== want[i] || outs !== expVec()) begin
        failures++; $display("FAIL reg0_rt case%0d got=%b exp=%b", i, outs, want[i]);
      end
      advance();
    end
  endtask

  task automatic test_md_sequence();
    logic [15:0] base;
    base = mSc;
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, 5'd1, 5'd2, 1'b1, 5'd1, t == 2, t == 0, 1'b0);
      checks++;
      if (outs !== expVec() || md_done !== (t == 3) || md_busy !== (t >= 1 && t <= 3)) begin
        failures++; $display("FAIL md_seq t%0d got=%b exp=%b", t, outs, expVec());
      end
      advance();
    end
    checks++;
    if (stall_cnt !== base + 16'd3) begin
      failures++; $display("FAIL md_stall_cnt got=%0d exp=%0d", stall_cnt, base + 16'd3);
    end
  endtask

  task automatic test_md_abort();
    for (int t = 0; t < 5; t++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, t == 0, t == 1);
      checks++;
      if (outs !== expVec() || md_done !== 1'b0 || (t == 1 && outs[9:2] !== 8'b11000111)
          || (t >= 2 && md_busy !== 1'b0)) begin
        failures++; $display("FAIL md_abort t%0d got=%b exp=%b", t, outs, expVec());
      end
      advance();
    end
  endtask

  task automatic test_priority();
    for (int t = 0; t < 2; t++) begin
      drive(1'b0, 5'd6, 5'd6, 1'b1, 5'd6, t == 0, t == 0, t == 0);
      checks++;
      if (outs !== ((t == 0) ? 10'b1100011100 : 10'b1100000000)) begin
        failures++; $display("FAIL priority t%0d got=%b exp=%b", t, outs, expVec());
      end
      advance();
    end
  endtask

  task automatic test_reset_in_md();
    for (int t = 0; t < 5; t++) begin
      drive(t == 2, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, t == 0, 1'b0);
      checks++;
      if (outs !== expVec() || md_done !== 1'b0 || (t == 2 && outs !== 10'b1100000000)) begin
        failures++; $display("FAIL reset_in_md t%0d got=%b exp=%b", t, outs, expVec());
      end
      if (t == 3) begin
        checks++;
        if (stall_cnt !== 16'd0 || md_busy !== 1'b0) begin
          failures++; $display("FAIL reset_in_md_state cnt=%0d busy=%b exp 0/0", stall_cnt, md_busy);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 49) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      checks++;
      if (outs !== expVec() || stall_cnt !== mSc) begin
        failures++;
        $display("FAIL random i%0d got=%b exp=%b cnt=%0d exp_cnt=%0d", i, outs, expVec(), stall_cnt, mSc);
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      failures++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL sat_reach got=%h exp=ffff", stall_cnt);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF || pc_write !== 1'b0) begin
      failures++; $display("FAIL sat_hold got=%h pcw=%b exp=ffff pcw=0", stall_cnt, pc_write);
    end
    mSc = 16'hFFFF;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    advance();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 16'hFFFF || outs !== expVec()) begin
      failures++; $display("FAIL sat_md got=%h outs=%b exp=ffff %b", stall_cnt, outs, expVec());
    end
    advance();
  endtask

  initial begin
    reset = 1'b1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0;
    ex_mem_read = 0; ex_md_start = 0; mem_br_taken = 0;
    test_reset();
    test_load_use();
    test_reg0_rt_unused();
    test_md_sequence();
    test_md_abort();
    test_priority();
    test_reset_in_md();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
